// File: rtl/agu_stq.sv
// DEPTH-entry circular store queue: in-order allocation, AGU capture, branch kill, load forwarding, DCache drain.
// Store-to-load forwarding CAM is built only when AGU_STQ_FWD_EN is defined; otherwise loads stall conservatively.
module agu_stq #(
   parameter int WIDTH_MEM = 4,
   parameter int WIDTH_BRM = 4,
   parameter int WIDTH_IDX = 3
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_alloc,
   input  logic [(1<<WIDTH_BRM)-1:0] i_alloc_brmask,
   output logic [WIDTH_IDX-1:0]      o_alloc_idx,
   output logic                      o_full,
   output logic                      o_empty,
   input  logic                      i_agu_val,
   input  logic [WIDTH_IDX-1:0]      i_agu_idx,
   input  logic [WIDTH_MEM-1:0]      i_agu_addr,
   input  logic [31:0]               i_agu_data,
   input  logic                      i_commit,
   input  logic [(1<<WIDTH_BRM)-1:0] i_brkill,
   input  logic [(1<<WIDTH_BRM)-1:0] i_brclear,
   input  logic                      i_ld_val,
   input  logic [WIDTH_MEM-1:0]      i_ld_addr,
   input  logic [WIDTH_IDX:0]        i_ld_tail,
   output logic                      o_fwd_hit,
   output logic [31:0]               o_fwd_data,
   output logic                      o_fwd_stall,
   output logic                      o_dc_val,
   output logic [WIDTH_MEM-1:0]      o_dc_addr,
   output logic [31:0]               o_dc_data,
   input  logic                      i_dc_rdy
);

   localparam int DEPTH = 1 << WIDTH_IDX;
   localparam int NBR   = 1 << WIDTH_BRM;
   localparam int PW    = WIDTH_IDX + 1;

   logic [DEPTH-1:0]     valid;
   logic [DEPTH-1:0]     addr_ok;
   logic [DEPTH-1:0]     committed;
   logic [NBR-1:0]       brmask [DEPTH];
   logic [WIDTH_MEM-1:0] addr   [DEPTH];
   logic [31:0]          data   [DEPTH];

   logic [PW-1:0]        head;
   logic [PW-1:0]        cmt;
   logic [PW-1:0]        tail;

   logic [WIDTH_IDX-1:0] head_idx;
   logic [WIDTH_IDX-1:0] cmt_idx;
   logic [WIDTH_IDX-1:0] tail_idx;

   logic                 full;
   logic                 empty;
   logic [DEPTH-1:0]     kill_vec;
   logic                 kill_any;
   logic [PW-1:0]        kill_ptr;
   logic [PW-1:0]        kill_span;
   logic [PW-1:0]        kscan_ptr;
   logic                 alloc_ok;
   logic                 agu_ok;
   logic                 cmt_ok;
   logic                 dc_val;
   logic                 dc_fire;

   logic [PW-1:0]        ld_span;
   logic [PW-1:0]        lscan_ptr;
   logic                 any_cand;

   // A load snapshot older than head has no older stores left in the queue.
   function automatic logic [PW-1:0] clamp_span(input logic [PW-1:0] d);
      return (d > PW'(DEPTH)) ? '0 : d;
   endfunction

   assign head_idx = head[WIDTH_IDX-1:0];
   assign cmt_idx  = cmt[WIDTH_IDX-1:0];
   assign tail_idx = tail[WIDTH_IDX-1:0];

   assign full  = (tail ^ head) == {1'b1, {WIDTH_IDX{1'b0}}};
   assign empty = (tail == head);

   assign o_alloc_idx = tail_idx;
   assign o_full      = full;
   assign o_empty     = empty;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         kill_vec[i] = valid[i] & ~committed[i] & (|(brmask[i] & i_brkill));
      end
   end

   assign kill_any  = |kill_vec;
   assign kill_span = tail - cmt;

   // Killed entries are a contiguous young suffix of [cmt, tail); the oldest one becomes the new tail.
   always_comb begin
      kill_ptr  = tail;
      kscan_ptr = cmt;
      for (int k = DEPTH-1; k >= 0; k--) begin
         kscan_ptr = cmt + PW'(k);
         if ((PW'(k) < kill_span) && kill_vec[kscan_ptr[WIDTH_IDX-1:0]]) begin
            kill_ptr = kscan_ptr;
         end
      end
   end

   assign alloc_ok = i_alloc && !full && !kill_any;
   assign agu_ok   = i_agu_val && valid[i_agu_idx] && !kill_vec[i_agu_idx];
   assign cmt_ok   = i_commit && (cmt != tail) && !kill_vec[cmt_idx];
   assign dc_val   = valid[head_idx] && committed[head_idx] && addr_ok[head_idx];
   assign dc_fire  = dc_val && i_dc_rdy;

   assign o_dc_val  = dc_val;
   assign o_dc_addr = addr[head_idx];
   assign o_dc_data = data[head_idx];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid     <= '0;
         addr_ok   <= '0;
         committed <= '0;
         head      <= '0;
         cmt       <= '0;
         tail      <= '0;
      end else begin
         if (alloc_ok) begin
            valid[tail_idx]     <= 1'b1;
            addr_ok[tail_idx]   <= 1'b0;
            committed[tail_idx] <= 1'b0;
         end
         if (agu_ok) begin
            addr_ok[i_agu_idx] <= 1'b1;
         end
         if (cmt_ok) begin
            committed[cmt_idx] <= 1'b1;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (kill_vec[i]) begin
               valid[i]   <= 1'b0;
               addr_ok[i] <= 1'b0;
            end
         end
         if (dc_fire) begin
            valid[head_idx]     <= 1'b0;
            addr_ok[head_idx]   <= 1'b0;
            committed[head_idx] <= 1'b0;
         end
         head <= head + {{WIDTH_IDX{1'b0}}, dc_fire};
         cmt  <= cmt + {{WIDTH_IDX{1'b0}}, cmt_ok};
         tail <= kill_any ? kill_ptr : (tail + {{WIDTH_IDX{1'b0}}, alloc_ok});
      end
   end

   always_ff @(posedge i_clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         brmask[i] <= brmask[i] & ~i_brclear;
      end
      if (alloc_ok) begin
         brmask[tail_idx] <= i_alloc_brmask & ~i_brclear;
      end
      if (agu_ok) begin
         addr[i_agu_idx] <= i_agu_addr;
         data[i_agu_idx] <= i_agu_data;
      end
   end

   assign ld_span = clamp_span(i_ld_tail - head);

`ifdef AGU_STQ_FWD_EN
   logic        any_unk;
   logic        cam_hit;
   logic [31:0] cam_data;
   logic        fwd_hit_p1;
   logic        fwd_stall_p1;
   logic [31:0] fwd_data_p1;

   // Scan oldest to youngest so the last match wins.
   always_comb begin
      any_cand  = 1'b0;
      any_unk   = 1'b0;
      cam_hit   = 1'b0;
      cam_data  = '0;
      lscan_ptr = head;
      for (int k = 0; k < DEPTH; k++) begin
         lscan_ptr = head + PW'(k);
         if ((PW'(k) < ld_span) && valid[lscan_ptr[WIDTH_IDX-1:0]]) begin
            any_cand = 1'b1;
            if (!addr_ok[lscan_ptr[WIDTH_IDX-1:0]]) begin
               any_unk = 1'b1;
            end else if (addr[lscan_ptr[WIDTH_IDX-1:0]] == i_ld_addr) begin
               cam_hit  = 1'b1;
               cam_data = data[lscan_ptr[WIDTH_IDX-1:0]];
            end
         end
      end
   end

   // Stage p1: registered forwarding result
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fwd_hit_p1   <= 1'b0;
         fwd_stall_p1 <= 1'b0;
         fwd_data_p1  <= '0;
      end else begin
         fwd_stall_p1 <= i_ld_val && any_unk;
         fwd_hit_p1   <= i_ld_val && !any_unk && cam_hit;
         fwd_data_p1  <= (i_ld_val && !any_unk && cam_hit) ? cam_data : 32'd0;
      end
   end

   assign o_fwd_hit   = fwd_hit_p1;
   assign o_fwd_stall = fwd_stall_p1;
   assign o_fwd_data  = fwd_data_p1;
`else
   logic fwd_stall_p1;
   logic unused_ld_addr;

   assign unused_ld_addr = ^i_ld_addr;

   always_comb begin
      any_cand  = 1'b0;
      lscan_ptr = head;
      for (int k = 0; k < DEPTH; k++) begin
         lscan_ptr = head + PW'(k);
         if ((PW'(k) < ld_span) && valid[lscan_ptr[WIDTH_IDX-1:0]]) begin
            any_cand = 1'b1;
         end
      end
   end

   // Stage p1: registered conservative stall
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fwd_stall_p1 <= 1'b0;
      end else begin
         fwd_stall_p1 <= i_ld_val && any_cand;
      end
   end

   assign o_fwd_hit   = 1'b0;
   assign o_fwd_stall = fwd_stall_p1;
   assign o_fwd_data  = 32'd0;
`endif

endmodule

// File: tb/tb_agu_stq.sv
// Directed, table-driven bench for agu_stq (default parameters); expectations follow AGU_STQ_FWD_EN.
module tb_agu_stq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alloc;
   logic [15:0] alloc_brmask;
   logic [2:0]  alloc_idx;
   logic        full;
   logic        empty;
   logic        agu_val;
   logic [2:0]  agu_idx;
   logic [3:0]  agu_addr;
   logic [31:0] agu_data;
   logic        commit;
   logic [15:0] brkill;
   logic [15:0] brclear;
   logic        ld_val;
   logic [3:0]  ld_addr;
   logic [3:0]  ld_tail;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic        fwd_stall;
   logic        dc_val;
   logic [3:0]  dc_addr;
   logic [31:0] dc_data;
   logic        dc_rdy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   agu_stq dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_alloc        (alloc),
      .i_alloc_brmask (alloc_brmask),
      .o_alloc_idx    (alloc_idx),
      .o_full         (full),
      .o_empty        (empty),
      .i_agu_val      (agu_val),
      .i_agu_idx      (agu_idx),
      .i_agu_addr     (agu_addr),
      .i_agu_data     (agu_data),
      .i_commit       (commit),
      .i_brkill       (brkill),
      .i_brclear      (brclear),
      .i_ld_val       (ld_val),
      .i_ld_addr      (ld_addr),
      .i_ld_tail      (ld_tail),
      .o_fwd_hit      (fwd_hit),
      .o_fwd_data     (fwd_data),
      .o_fwd_stall    (fwd_stall),
      .o_dc_val       (dc_val),
      .o_dc_addr      (dc_addr),
      .o_dc_data      (dc_data),
      .i_dc_rdy       (dc_rdy)
   );

   // Expected forwarding fields describe the load applied in the previous row.
   typedef struct {
      logic        al;
      logic [15:0] bm;
      logic        av;
      logic [2:0]  ai;
      logic [3:0]  aa;
      logic [31:0] ad;
      logic        cm;
      logic [15:0] bk;
      logic [15:0] bc;
      logic        lv;
      logic [3:0]  la;
      logic [3:0]  lt;
      logic        rdy;
      logic [2:0]  e_idx;
      logic        e_full;
      logic        e_empty;
      logic        e_dcv;
      logic [3:0]  e_dca;
      logic [31:0] e_dcd;
      logic        e_hit;
      logic [31:0] e_fd;
      logic        e_stall;
      logic        e_cand;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t V(
      input int al, input int bm, input int av, input int ai, input int aa, input int ad,
      input int cm, input int bk, input int bc, input int lv, input int la, input int lt,
      input int rdy, input int e_idx, input int e_full, input int e_empty, input int e_dcv,
      input int e_dca, input int e_dcd, input int e_hit, input int e_fd, input int e_stall,
      input int e_cand);
      vec_t r;
      r.al = 1'(al);   r.bm = 16'(bm); r.av = 1'(av); r.ai = 3'(ai); r.aa = 4'(aa);
      r.ad = 32'(ad);  r.cm = 1'(cm);  r.bk = 16'(bk); r.bc = 16'(bc); r.lv = 1'(lv);
      r.la = 4'(la);   r.lt = 4'(lt);  r.rdy = 1'(rdy);
      r.e_idx = 3'(e_idx); r.e_full = 1'(e_full); r.e_empty = 1'(e_empty);
      r.e_dcv = 1'(e_dcv); r.e_dca = 4'(e_dca); r.e_dcd = 32'(e_dcd);
      r.e_hit = 1'(e_hit); r.e_fd = 32'(e_fd); r.e_stall = 1'(e_stall); r.e_cand = 1'(e_cand);
      return r;
   endfunction

   task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", nm, row, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      alloc = v.al;  alloc_brmask = v.bm;
      agu_val = v.av; agu_idx = v.ai; agu_addr = v.aa; agu_data = v.ad;
      commit = v.cm; brkill = v.bk; brclear = v.bc;
      ld_val = v.lv; ld_addr = v.la; ld_tail = v.lt;
      dc_rdy = v.rdy;
   endtask

   task automatic chk_idle_outputs(input int row);
      chk("dc_val", row, 32'(dc_val), 32'd0);
      chk("empty", row, 32'(empty), 32'd1);
      chk("full", row, 32'(full), 32'd0);
      chk("alloc_idx", row, 32'(alloc_idx), 32'd0);
      chk("fwd_hit", row, 32'(fwd_hit), 32'd0);
      chk("fwd_stall", row, 32'(fwd_stall), 32'd0);
      chk("fwd_data", row, fwd_data, 32'd0);
   endtask

   initial begin
      vec_t v;
      logic        x_hit;
      logic [31:0] x_fd;
      logic        x_stall;

      //   al  bm      av ai aa ad     cm bk      bc   lv la lt rdy | idx fu em dcv dca dcd   hit fd    st cand
      tbl.push_back(V(1,'h8000, 0,0,0,0,     0,0,     0,   0,0,0, 0,   0,0,1, 0,0,0,     0,0,    0,0));
      for (int i = 1; i < 8; i++)
         tbl.push_back(V(1,'h8000, 0,0,0,0, 0,0,     0,   0,0,0, 0,   i,0,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(1,'h8000, 0,0,0,0,     0,0,     0,   0,0,0, 0,   0,1,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(0,0,      0,0,0,0,     0,'h8000,0,   0,0,0, 0,   0,1,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(1,0,      0,0,0,0,     0,0,     0,   0,0,0, 0,   0,0,1, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(1,0,      1,0,4,'hAA,  0,0,     0,   0,0,0, 0,   1,0,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(0,0,      1,1,4,'hBB,  0,0,     0,   0,0,0, 0,   2,0,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(0,0,      0,0,0,0,     0,0,     0,   1,4,2, 0,   2,0,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(1,0,      0,0,0,0,     0,0,     0,   0,0,0, 0,   2,0,0, 0,0,0,     1,'hBB, 0,1));
      tbl.push_back(V(1,0,      1,2,5,'hCC,  0,0,     0,   0,0,0, 0,   3,0,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(0,0,      0,0,0,0,     0,0,     0,   1,4,4, 0,   4,0,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(0,0,      0,0,0,0,     0,0,     0,   1,5,3, 0,   4,0,0, 0,0,0,     0,0,    1,1));
      tbl.push_back(V(0,0,      0,0,0,0,     0,0,     0,   1,9,3, 0,   4,0,0, 0,0,0,     1,'hCC, 0,1));
      tbl.push_back(V(1,'h1,    0,0,0,0,     0,0,     0,   0,0,0, 0,   4,0,0, 0,0,0,     0,0,    0,1));
      tbl.push_back(V(1,'h2,    0,0,0,0,     0,0,     0,   0,0,0, 0,   5,0,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(1,'h2,    0,0,0,0,     0,0,     0,   0,0,0, 0,   6,0,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(1,0,      1,5,4,'hDD,  0,'h2,   0,   0,0,0, 0,   7,0,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(0,0,      1,4,6,'h44,  0,0,     0,   0,0,0, 0,   5,0,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(1,0,      0,0,0,0,     0,0,     0,   1,4,5, 0,   5,0,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(0,0,      0,0,0,0,     0,0,     'h1, 0,0,0, 0,   6,0,0, 0,0,0,     1,'hBB, 0,1));
      tbl.push_back(V(0,0,      0,0,0,0,     0,'h1,   0,   0,0,0, 0,   6,0,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(0,0,      0,0,0,0,     1,0,     0,   0,0,0, 0,   6,0,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(0,0,      0,0,0,0,     1,0,     0,   0,0,0, 0,   6,0,0, 1,4,'hAA,  0,0,    0,0));
      tbl.push_back(V(0,0,      0,0,0,0,     0,0,     0,   0,0,0, 0,   6,0,0, 1,4,'hAA,  0,0,    0,0));
      tbl.push_back(V(0,0,      0,0,0,0,     0,0,     0,   0,0,0, 0,   6,0,0, 1,4,'hAA,  0,0,    0,0));
      tbl.push_back(V(0,0,      0,0,0,0,     0,0,     0,   0,0,0, 1,   6,0,0, 1,4,'hAA,  0,0,    0,0));
      tbl.push_back(V(0,0,      0,0,0,0,     0,0,     0,   0,0,0, 1,   6,0,0, 1,4,'hBB,  0,0,    0,0));
      tbl.push_back(V(0,0,      0,0,0,0,     1,0,     0,   0,0,0, 1,   6,0,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(0,0,      1,3,7,'h33,  1,0,     0,   0,0,0, 1,   6,0,0, 1,5,'hCC,  0,0,    0,0));
      tbl.push_back(V(0,0,      0,0,0,0,     1,0,     0,   0,0,0, 1,   6,0,0, 1,7,'h33,  0,0,    0,0));
      tbl.push_back(V(0,0,      1,5,8,'h55,  1,0,     0,   0,0,0, 1,   6,0,0, 1,6,'h44,  0,0,    0,0));
      tbl.push_back(V(0,0,      0,0,0,0,     0,0,     0,   0,0,0, 1,   6,0,0, 1,8,'h55,  0,0,    0,0));
      tbl.push_back(V(1,0,      0,0,0,0,     0,0,     0,   0,0,0, 0,   6,0,1, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(1,0,      1,6,3,'h61,  0,0,     0,   0,0,0, 0,   7,0,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(1,0,      1,7,3,'h71,  0,0,     0,   0,0,0, 0,   0,0,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(1,0,      1,0,3,'h01,  0,0,     0,   0,0,0, 0,   1,0,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(0,0,      1,1,2,'h11,  0,0,     0,   1,3,9, 0,   2,0,0, 0,0,0,     0,0,    0,0));
      tbl.push_back(V(0,0,      0,0,0,0,     0,0,     0,   1,3,8, 0,   2,0,0, 0,0,0,     1,'h01, 0,1));
      tbl.push_back(V(0,0,      0,0,0,0,     0,0,     0,   1,2,10,0,   2,0,0, 0,0,0,     1,'h71, 0,1));
      tbl.push_back(V(0,0,      0,0,0,0,     1,0,     0,   0,0,0, 1,   2,0,0, 0,0,0,     1,'h11, 0,1));
      tbl.push_back(V(0,0,      0,0,0,0,     1,0,     0,   0,0,0, 1,   2,0,0, 1,3,'h61,  0,0,    0,0));
      tbl.push_back(V(0,0,      0,0,0,0,     1,0,     0,   0,0,0, 1,   2,0,0, 1,3,'h71,  0,0,    0,0));
      tbl.push_back(V(0,0,      0,0,0,0,     1,0,     0,   0,0,0, 1,   2,0,0, 1,3,'h01,  0,0,    0,0));
      tbl.push_back(V(0,0,      0,0,0,0,     0,0,     0,   0,0,0, 0,   2,0,0, 1,2,'h11,  0,0,    0,0));

      rst_n = 1'b0;
      drive(V(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
      repeat (2) @(negedge clk);
      #1;
      chk_idle_outputs(-1);
      rst_n = 1'b1;

      for (int r = 0; r < tbl.size(); r++) begin
         @(negedge clk);
         v = tbl[r];
         drive(v);
         #1;
`ifdef AGU_STQ_FWD_EN
         x_hit   = v.e_hit;
         x_fd    = v.e_fd;
         x_stall = v.e_stall;
`else
         x_hit   = 1'b0;
         x_fd    = 32'd0;
         x_stall = v.e_cand;
`endif
         chk("alloc_idx", r, 32'(alloc_idx), 32'(v.e_idx));
         chk("full", r, 32'(full), 32'(v.e_full));
         chk("empty", r, 32'(empty), 32'(v.e_empty));
         chk("dc_val", r, 32'(dc_val), 32'(v.e_dcv));
         if (v.e_dcv) begin
            chk("dc_addr", r, 32'(dc_addr), 32'(v.e_dca));
            chk("dc_data", r, dc_data, v.e_dcd);
         end
         chk("fwd_hit", r, 32'(fwd_hit), 32'(x_hit));
         chk("fwd_data", r, fwd_data, x_fd);
         chk("fwd_stall", r, 32'(fwd_stall), 32'(x_stall));
      end

      // Reset while a drain is pending must drop o_dc_val without waiting for a clock edge.
      @(negedge clk);
      drive(V(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
      #1;
      chk("dc_val_pre_rst", 100, 32'(dc_val), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_idle_outputs(101);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk_idle_outputs(102);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
